// File: rtl/key_event_queue_if.sv
// rtl/key_event_queue_if.sv - key event stream handshake between the queue and its consumer
interface key_event_queue_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [3:0] evt_code;
  logic       evt_repeat;

  modport master (
    output evt_valid,
    output evt_code,
    output evt_repeat,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_code,
    input  evt_repeat,
    output evt_ready
  );
endinterface

// File: rtl/key_event_queue.sv
// rtl/key_event_queue.sv - turns debounced key levels into fresh/auto-repeat events queued in an FWFT FIFO
module key_event_queue #(
  parameter logic [19:0] REPEAT_DELAY = 20'd1_000_000,
  parameter logic [19:0] REPEAT_RATE  = 20'd250_000,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [15:0]              key_deb,
  key_event_queue_if.master        evt,
  output logic                     overflow,
  output logic [7:0]               drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rep_state_t;

  logic [15:0] key_prev_q, key_prev_d;
  logic [15:0] pend_q, pend_d;
  logic [15:0] new_keys, cand;
  logic        fresh_req;
  logic [3:0]  fresh_k;

  rep_state_t  state_q, state_d;
  logic [3:0]  act_q, act_d;
  logic [19:0] rcnt_q, rcnt_d;
  logic        rep_req_q, rep_req_d;

  logic [4:0]  mem_q [FIFO_DEPTH];
  logic [4:0]  mem_d [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        overflow_q, overflow_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;

  logic        empty, full, pop, push_req, push_ok, drop;
  logic [4:0]  push_entry;

  // Fresh arbitration: lowest-numbered candidate wins, the rest stay pending.
  always_comb begin
    key_prev_d = key_deb;
    new_keys   = key_deb & ~key_prev_q;
    cand       = pend_q | new_keys;
    fresh_req  = |cand;
    fresh_k    = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (cand[i]) fresh_k = 4'(i);
    end
    pend_d = fresh_req ? (cand & ~(16'd1 << fresh_k)) : cand;
  end

  always_comb begin
    empty      = (wr_ptr_q == rd_ptr_q);
    full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop        = !empty && evt.evt_ready;
    push_req   = fresh_req || rep_req_q;
    push_entry = fresh_req ? {fresh_k, 1'b0} : {act_q, 1'b1};
    push_ok    = push_req && (!full || pop);
    drop       = push_req && full && !pop;

    mem_d = mem_q;
    if (push_ok) mem_d[wr_ptr_q[AW-1:0]] = push_entry;
    wr_ptr_d   = wr_ptr_q + (AW+1)'(push_ok);
    rd_ptr_d   = rd_ptr_q + (AW+1)'(pop);
    overflow_d = drop;
    drop_cnt_d = (drop && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
  end

  // Any pending repeat is consumed every cycle (served, dropped or superseded
  // by a fresh event), so rep_req only survives when the timer re-arms it.
  always_comb begin
    state_d   = state_q;
    act_d     = act_q;
    rcnt_d    = rcnt_q;
    rep_req_d = 1'b0;
    if (fresh_req) begin
      state_d = DELAY;
      act_d   = fresh_k;
      rcnt_d  = 20'd0;
    end else if (state_q != IDLE && !key_deb[act_q]) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        DELAY: begin
          if (rcnt_q == REPEAT_DELAY - 20'd1) begin
            rep_req_d = 1'b1;
            rcnt_d    = 20'd0;
            state_d   = REPEAT;
          end else begin
            rcnt_d = rcnt_q + 20'd1;
          end
        end
        REPEAT: begin
          if (rcnt_q == REPEAT_RATE - 20'd1) begin
            rep_req_d = 1'b1;
            rcnt_d    = 20'd0;
          end else begin
            rcnt_d = rcnt_q + 20'd1;
          end
        end
        default: begin
          rcnt_d = rcnt_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_prev_q <= 16'd0;
      pend_q     <= 16'd0;
      state_q    <= IDLE;
      act_q      <= 4'd0;
      rcnt_q     <= 20'd0;
      rep_req_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 8'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 5'd0;
    end else begin
      key_prev_q <= key_prev_d;
      pend_q     <= pend_d;
      state_q    <= state_d;
      act_q      <= act_d;
      rcnt_q     <= rcnt_d;
      rep_req_q  <= rep_req_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign evt.evt_valid  = !empty;
  assign evt.evt_code   = mem_q[rd_ptr_q[AW-1:0]][4:1];
  assign evt.evt_repeat = mem_q[rd_ptr_q[AW-1:0]][0];
  assign overflow       = overflow_q;
  assign drop_cnt       = drop_cnt_q;

endmodule

// File: tb/tb_key_event_queue.sv
// tb/tb_key_event_queue.sv - directed self-checking bench for key_event_queue
module tb_key_event_queue;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] key_deb;
  logic        overflow;
  logic [7:0]  drop_cnt;

  key_event_queue_if ifc ();

  key_event_queue #(
    .REPEAT_DELAY (20'd10),
    .REPEAT_RATE  (20'd4),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_deb  (key_deb),
    .evt      (ifc.master),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int ovf_cnt = 0;
  logic [3:0] ev_code [$];
  logic       ev_rep  [$];
  int         ev_cyc  [$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      if (ifc.evt_valid && ifc.evt_ready) begin
        ev_code.push_back(ifc.evt_code);
        ev_rep.push_back(ifc.evt_repeat);
        ev_cyc.push_back(cyc);
      end
      if (overflow) ovf_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_log();
    ev_code.delete();
    ev_rep.delete();
    ev_cyc.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    key_deb = 16'h0000;
    ifc.evt_ready = 1'b1;
    tick(2);
    @(negedge clk);
    vectors++; if (ifc.evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ifc.evt_valid); end
    vectors++; if (ifc.evt_code !== 4'd0) begin errors++; $display("FAIL reset_code got %0d exp 0", ifc.evt_code); end
    vectors++; if (ifc.evt_repeat !== 1'b0) begin errors++; $display("FAIL reset_repeat got %b exp 0", ifc.evt_repeat); end
    vectors++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    vectors++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop_cnt got %0d exp 0", drop_cnt); end
    tick(1);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_single_press();
    int c;
    clear_log();
    c = cyc;
    key_deb = 16'h0020;
    tick(8);
    key_deb = 16'h0000;
    tick(20);
    vectors++; if (ev_code.size() !== 1) begin errors++; $display("FAIL single_count got %0d exp 1", ev_code.size()); end
    if (ev_code.size() >= 1) begin
      vectors++; if (ev_code[0] !== 4'd5) begin errors++; $display("FAIL single_code got %0d exp 5", ev_code[0]); end
      vectors++; if (ev_rep[0] !== 1'b0) begin errors++; $display("FAIL single_repeat got %b exp 0", ev_rep[0]); end
      vectors++; if (ev_cyc[0] !== c + 1) begin errors++; $display("FAIL single_latency got %0d exp %0d", ev_cyc[0], c + 1); end
    end
  endtask

  task automatic test_simultaneous();
    int c;
    logic [3:0] exp_code [3] = '{4'd0, 4'd8, 4'd15};
    clear_log();
    c = cyc;
    key_deb = 16'h8101;
    tick(2);
    key_deb = 16'h0000;
    tick(10);
    vectors++; if (ev_code.size() !== 3) begin errors++; $display("FAIL simul_count got %0d exp 3", ev_code.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < ev_code.size()) begin
        vectors++;
        if (ev_code[i] !== exp_code[i] || ev_rep[i] !== 1'b0 || ev_cyc[i] !== c + 1 + i) begin
          errors++;
          $display("FAIL simul_evt%0d got code=%0d rep=%b cyc=%0d exp code=%0d rep=0 cyc=%0d",
                   i, ev_code[i], ev_rep[i], ev_cyc[i], exp_code[i], c + 1 + i);
        end
      end
    end
  endtask

  task automatic test_auto_repeat();
    int c;
    int t0;
    int exp_off [6] = '{0, 11, 15, 19, 23, 27};
    clear_log();
    c = cyc;
    t0 = c + 1;
    key_deb = 16'h0008;
    tick(30);
    key_deb = 16'h0000;
    tick(20);
    vectors++; if (ev_code.size() !== 6) begin errors++; $display("FAIL repeat_count got %0d exp 6", ev_code.size()); end
    for (int i = 0; i < 6; i++) begin
      if (i < ev_code.size()) begin
        vectors++;
        if (ev_code[i] !== 4'd3 || ev_rep[i] !== (i != 0) || ev_cyc[i] !== t0 + exp_off[i]) begin
          errors++;
          $display("FAIL repeat_evt%0d got code=%0d rep=%b cyc=%0d exp code=3 rep=%b cyc=%0d",
                   i, ev_code[i], ev_rep[i], ev_cyc[i], (i != 0), t0 + exp_off[i]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    int base;
    clear_log();
    base = ovf_cnt;
    ifc.evt_ready = 1'b0;
    key_deb = 16'h003F;
    tick(1);
    key_deb = 16'h0000;
    tick(10);
    vectors++; if (ovf_cnt - base !== 2) begin errors++; $display("FAIL ovf_pulses got %0d exp 2", ovf_cnt - base); end
    vectors++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL ovf_drop_cnt got %0d exp 2", drop_cnt); end
    vectors++; if (ifc.evt_valid !== 1'b1 || ifc.evt_code !== 4'd0) begin
      errors++; $display("FAIL ovf_head got valid=%b code=%0d exp valid=1 code=0", ifc.evt_valid, ifc.evt_code);
    end
    ifc.evt_ready = 1'b1;
    tick(8);
    vectors++; if (ev_code.size() !== 4) begin errors++; $display("FAIL ovf_drain_count got %0d exp 4", ev_code.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < ev_code.size()) begin
        vectors++;
        if (ev_code[i] !== 4'(i) || ev_rep[i] !== 1'b0) begin
          errors++; $display("FAIL ovf_drain%0d got code=%0d rep=%b exp code=%0d rep=0", i, ev_code[i], ev_rep[i], i);
        end
      end
    end
  endtask

  task automatic test_full_with_pop();
    int base;
    logic [3:0] exp_code [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd8};
    ifc.evt_ready = 1'b0;
    key_deb = 16'h000F;
    tick(1);
    key_deb = 16'h0000;
    tick(6);
    clear_log();
    base = ovf_cnt;
    ifc.evt_ready = 1'b1;
    key_deb = 16'h0100;
    tick(1);
    ifc.evt_ready = 1'b0;
    key_deb = 16'h0000;
    tick(3);
    vectors++; if (ovf_cnt - base !== 0) begin errors++; $display("FAIL fullpop_overflow got %0d pulses exp 0", ovf_cnt - base); end
    vectors++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL fullpop_drop_cnt got %0d exp 2", drop_cnt); end
    ifc.evt_ready = 1'b1;
    tick(8);
    vectors++; if (ev_code.size() !== 5) begin errors++; $display("FAIL fullpop_count got %0d exp 5", ev_code.size()); end
    for (int i = 0; i < 5; i++) begin
      if (i < ev_code.size()) begin
        vectors++;
        if (ev_code[i] !== exp_code[i] || ev_rep[i] !== 1'b0) begin
          errors++; $display("FAIL fullpop_evt%0d got code=%0d rep=%b exp code=%0d rep=0", i, ev_code[i], ev_rep[i], exp_code[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    ifc.evt_ready = 1'b0;
    key_deb = 16'h0007;
    tick(1);
    key_deb = 16'h0000;
    tick(5);
    vectors++; if (ifc.evt_valid !== 1'b1) begin errors++; $display("FAIL rmid_queued got valid=%b exp 1", ifc.evt_valid); end
    key_deb = 16'h0080;
    rst = 1'b1;
    @(negedge clk);
    vectors++; if (ifc.evt_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b exp 0", ifc.evt_valid); end
    vectors++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL rmid_drop_cnt got %0d exp 0", drop_cnt); end
    tick(3);
    clear_log();
    rst = 1'b0;
    ifc.evt_ready = 1'b1;
    tick(5);
    key_deb = 16'h0000;
    tick(5);
    vectors++; if (ev_code.size() !== 1) begin errors++; $display("FAIL rmid_count got %0d exp 1", ev_code.size()); end
    if (ev_code.size() >= 1) begin
      vectors++;
      if (ev_code[0] !== 4'd7 || ev_rep[0] !== 1'b0) begin
        errors++; $display("FAIL rmid_evt got code=%0d rep=%b exp code=7 rep=0", ev_code[0], ev_rep[0]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    key_deb = 16'h0000;
    ifc.evt_ready = 1'b1;
    test_reset();
    test_single_press();
    test_simultaneous();
    test_auto_repeat();
    test_overflow();
    test_full_with_pop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
